button_mem_loader: RTL and testbench

- Writer side of the button sprite memory: streams RGB888 image data into the dual-region button RAM that the button pixel renderer reads.
- Accepts an 8-bit byte stream with a valid/ready handshake, for example from the HPS bridge or a UART.
- Assembles R, G, B bytes into 24-bit pixels and writes one button image (155x38 pixels) row-major into the region selected by button_type.
- Sits between the byte source and the write port of buttons_mem; uses the same clock as the read side.

---
 rtl/button_mem_loader.sv | 148 ++++++++++++++
 tb/tb_button_mem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_mem_loader.sv
// Button sprite memory writer: packs an R,G,B byte stream into 24-bit pixels and
// writes one IMG_W x IMG_H image row-major into the region picked by button_type.
module button_mem_loader #(
  parameter int unsigned IMG_W  = 155,
  parameter int unsigned IMG_H  = 38,
  parameter int unsigned BASE1  = 5890,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              button_type,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] Base1Addr = ADDR_W'(BASE1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StFinish = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      byte_idx_q <= '0;
      addr_q     <= '0;
      r_q        <= '0;
      g_q        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      r_q        <= r_d;
      g_q        <= g_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    r_d        = r_q;
    g_d        = g_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d     = button_type ? Base1Addr : '0;
          x_d        = '0;
          y_d        = '0;
          byte_idx_d = '0;
          state_d    = StLoad;
        end
      end

      StLoad: begin
        // in_ready is constant 1 here, so in_valid alone marks a transfer.
        if (in_valid) begin
          unique case (byte_idx_q)
            2'd0: begin
              r_d        = in_data;
              byte_idx_d = 2'd1;
            end
            2'd1: begin
              g_d        = in_data;
              byte_idx_d = 2'd2;
            end
            default: begin
              byte_idx_d = 2'd0;
              wr_en_d    = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = {r_q, g_q, in_data};
              addr_d     = addr_q + 1'b1;
              if (x_q == XLast) begin
                x_d = '0;
                y_d = y_q + 1'b1;
                if (y_q == YLast) begin
                  state_d = StFinish;
                end
              end else begin
                x_d = x_q + 1'b1;
              end
            end
          endcase
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q != StIdle);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_button_mem_loader.sv
// Directed bench for button_mem_loader: reset, full loads of both regions, gaps,
// ignored start, mid-load reset and byte assembly.
module tb_button_mem_loader;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        button_type = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  button_mem_loader dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .start      (start),
    .button_type(button_type),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 vga_clk = ~vga_clk;

  // Write monitor: counts writes, checks address order, data against the bytes
  // actually transferred, and that writes occur exactly one cycle after a B byte.
  logic        mon_clr = 1'b0;
  int          wr_cnt, done_cnt, ord_err, data_err, pend_err, nb;
  int          first_addr, last_addr, addr313, exp_addr;
  logic [23:0] first_data, exp_pix;
  logic [7:0]  pb [3];
  logic        pend;

  always @(negedge vga_clk) begin
    if (mon_clr || reset) begin
      wr_cnt = 0; done_cnt = 0; ord_err = 0; data_err = 0; pend_err = 0; nb = 0;
      first_addr = -1; last_addr = -1; addr313 = -1; exp_addr = 0;
      first_data = '0; exp_pix = '0; pend = 1'b0;
    end else begin
      if (wr_en !== pend) pend_err++;
      if (wr_en === 1'b1) begin
        if (wr_cnt == 0) begin
          first_addr = int'(wr_addr);
          first_data = wr_data;
          exp_addr   = int'(wr_addr);
        end
        if (int'(wr_addr) != exp_addr) ord_err++;
        if (wr_data !== exp_pix) data_err++;
        if (wr_cnt == 313) addr313 = int'(wr_addr);
        last_addr = int'(wr_addr);
        exp_addr++;
        wr_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      pend = 1'b0;
      if (in_valid && in_ready) begin
        pb[nb % 3] = in_data;
        nb++;
        if (nb % 3 == 0) begin
          pend    = 1'b1;
          exp_pix = {pb[0], pb[1], pb[2]};
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] bval(input int n);
    return 8'((n + 1) * 17);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic do_start(input logic bt);
    start       = 1'b1;
    button_type = bt;
    tick(1);
    start       = 1'b0;
  endtask

  // Sends nbytes stream bytes; with gaps, in_valid drops on ~1/4 of cycles.
  task automatic stream(input int nbytes, input bit gaps, input int base_idx);
    int sent  = 0;
    int guard = 0;
    bit xf;
    while (sent < nbytes && guard < 60000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = bval(base_idx + sent);
      end
      xf = in_valid && in_ready;
      tick(1);
      if (xf) sent++;
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_bytes_accepted", 32'(sent), 32'(nbytes));
  endtask

  task automatic send1(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with start and in_valid active.
    #2;
    reset    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    tick(2);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick(8);
    chk("idle_no_writes", 32'(wr_cnt), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Region 0, one byte per cycle.
    clr_mon();
    do_start(1'b0);
    chk("r0_busy", 32'(busy), 32'd1);
    chk("r0_in_ready", 32'(in_ready), 32'd1);
    stream(17670, 1'b0, 0);
    chk("r0_last_wr_en", 32'(wr_en), 32'd1);
    chk("r0_last_addr", 32'(wr_addr), 32'd5889);
    chk("r0_last_busy", 32'(busy), 32'd1);
    chk("r0_last_in_ready", 32'(in_ready), 32'd0);
    chk("r0_last_done", 32'(done), 32'd0);
    tick(1);
    chk("r0_done_pulse", 32'(done), 32'd1);
    chk("r0_done_busy", 32'(busy), 32'd0);
    chk("r0_done_wr_en", 32'(wr_en), 32'd0);
    chk("r0_addr_hold", 32'(wr_addr), 32'd5889);
    tick(1);
    chk("r0_done_single", 32'(done), 32'd0);
    tick(3);
    chk("r0_first_addr", 32'(first_addr), 32'd0);
    chk("r0_first_data", 32'(first_data), 32'h112233);
    chk("r0_write_count", 32'(wr_cnt), 32'd5890);
    chk("r0_order", 32'(ord_err), 32'd0);
    chk("r0_data", 32'(data_err), 32'd0);
    chk("r0_timing", 32'(pend_err), 32'd0);
    chk("r0_done_count", 32'(done_cnt), 32'd1);

    // Region 1 with gaps and an ignored start mid-load.
    clr_mon();
    do_start(1'b1);
    stream(9000, 1'b1, 0);
    do_start(1'b0);
    chk("r1_busy_after_start", 32'(busy), 32'd1);
    stream(8670, 1'b1, 9000);
    chk("r1_last_wr_en", 32'(wr_en), 32'd1);
    chk("r1_last_addr", 32'(wr_addr), 32'd11779);
    chk("r1_last_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    chk("r1_done_pulse", 32'(done), 32'd1);
    chk("r1_done_busy", 32'(busy), 32'd0);
    tick(4);
    chk("r1_first_addr", 32'(first_addr), 32'd5890);
    chk("r1_x3_y2_addr", 32'(addr313), 32'd6203);
    chk("r1_last_addr_mon", 32'(last_addr), 32'd11779);
    chk("r1_write_count", 32'(wr_cnt), 32'd5890);
    chk("r1_order", 32'(ord_err), 32'd0);
    chk("r1_data", 32'(data_err), 32'd0);
    chk("r1_no_gap_writes", 32'(pend_err), 32'd0);
    chk("r1_done_count", 32'(done_cnt), 32'd1);

    // Reset after 1000 pixels plus 2 bytes.
    clr_mon();
    do_start(1'b1);
    stream(3002, 1'b0, 0);
    chk("mid_write_count", 32'(wr_cnt), 32'd1000);
    chk("mid_done_count", 32'(done_cnt), 32'd0);
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(6);
    in_valid = 1'b0;
    chk("post_rst_writes", 32'(wr_cnt), 32'd0);
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Restart in region 0 with bytes spaced 5 cycles apart.
    do_start(1'b0);
    send1(8'hFF);
    tick(4);
    send1(8'h00);
    chk("asm_no_write_after_g", 32'(wr_en), 32'd0);
    tick(4);
    send1(8'h80);
    chk("asm_wr_en", 32'(wr_en), 32'd1);
    chk("asm_wr_data", 32'(wr_data), 32'hFF0080);
    chk("asm_wr_addr", 32'(wr_addr), 32'd0);
    tick(1);
    chk("asm_single_pulse", 32'(wr_en), 32'd0);
    chk("asm_data_hold", 32'(wr_data), 32'hFF0080);
    chk("asm_timing", 32'(pend_err), 32'd0);
    chk("asm_write_count", 32'(wr_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
